// File: rtl/cpu_test_ctrl.sv
// cpu_test_ctrl: reset/run sequencer for CPU bring-up with signature-based pass/fail/timeout.
// Define CPU_TEST_WBCOUNT_EN to build the non-r0 write-back counter on wb_count_o.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_RST_PH | core held in reset for RST_CYCLES cycles
// S_RUN    | core running, watching write-back for the signature
// S_DONE   | core frozen, result flags and cycle count held
module cpu_test_ctrl #(
    parameter int RST_CYCLES = 10,
    parameter int RUN_CYCLES = 15,
    parameter int CNT_W      = 16,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int SIG_ADDR   = 2,
    parameter int PASS_VALUE = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              restart_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              core_rst_o,
    output logic              running_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  cycles_o,
    output logic [CNT_W-1:0]  wb_count_o
);

    typedef enum logic [1:0] {
        S_RST_PH = 2'd0,
        S_RUN    = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] SIG_A    = ADDR_W'(SIG_ADDR);
    localparam logic [DATA_W-1:0] PASS_V   = DATA_W'(PASS_VALUE);
    localparam bit                SIG_OK   = (SIG_ADDR != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             timeout_q, timeout_d;

    logic wb_valid;
    logic sig_hit;
    logic rst_end;
    logic run_end;

    // r0 writes never count and can never be the signature
    assign wb_valid = wb_we_i && (wb_addr_i != '0);
    assign sig_hit  = SIG_OK && wb_valid && (wb_addr_i == SIG_A);
    assign rst_end  = (cnt_q == RST_LAST);
    assign run_end  = (cycles_q == RUN_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RST_PH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST_PH: if (rst_end) state_d = S_RUN;
            S_RUN:    if (sig_hit || run_end) state_d = S_DONE;
            S_DONE:   if (restart_i) state_d = S_RST_PH;
            default:  state_d = S_RST_PH;
        endcase
    end

    always_comb begin
        core_rst_o = 1'b1;
        running_o  = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            S_RUN: begin
                core_rst_o = 1'b0;
                running_o  = 1'b1;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // signature takes priority over the last-cycle timeout
    always_comb begin
        cnt_d     = cnt_q;
        cycles_d  = cycles_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        case (state_q)
            S_RST_PH: cnt_d = rst_end ? '0 : cnt_q + CNT_W'(1);
            S_RUN: begin
                if (sig_hit) begin
                    pass_d = (wb_data_i == PASS_V);
                    fail_d = (wb_data_i != PASS_V);
                end else if (run_end) begin
                    timeout_d = 1'b1;
                end else begin
                    cycles_d = cycles_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (restart_i) begin
                    cnt_d     = '0;
                    cycles_d  = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            cycles_q  <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cycles_q  <= cycles_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
        end
    end

    assign pass_o    = pass_q;
    assign fail_o    = fail_q;
    assign timeout_o = timeout_q;
    assign cycles_o  = cycles_q;

`ifdef CPU_TEST_WBCOUNT_EN
    logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

    always_comb begin
        wb_cnt_d = wb_cnt_q;
        if (state_q == S_RUN && wb_valid && wb_cnt_q != '1) begin
            wb_cnt_d = wb_cnt_q + CNT_W'(1);
        end else if (state_q == S_DONE && restart_i) begin
            wb_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_cnt_q <= '0;
        end else begin
            wb_cnt_q <= wb_cnt_d;
        end
    end

    assign wb_count_o = wb_cnt_q;
`else
    assign wb_count_o = '0;
`endif

endmodule

// File: tb/tb_cpu_test_ctrl.sv
// Bench for cpu_test_ctrl: directed trial table, hand sequences and randomized trials
// checked against a trial-level timeline model.
module tb_cpu_test_ctrl;

    localparam int RSTC  = 4;
    localparam int RUNC  = 8;
    localparam int CW    = 16;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int SIGA  = 2;
    localparam int PASSV = 1;

    logic          clk = 1'b0;
    logic          rst, restart, wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          core_rst, running, done, pass, fail, timeout;
    logic [CW-1:0] cycles, wb_count;

    cpu_test_ctrl #(
        .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC), .CNT_W(CW), .DATA_W(DW),
        .ADDR_W(AW), .SIG_ADDR(SIGA), .PASS_VALUE(PASSV)
    ) dut (
        .clk_i(clk), .rst_i(rst), .restart_i(restart), .wb_we_i(wb_we),
        .wb_addr_i(wb_addr), .wb_data_i(wb_data), .core_rst_o(core_rst),
        .running_o(running), .done_o(done), .pass_o(pass), .fail_o(fail),
        .timeout_o(timeout), .cycles_o(cycles), .wb_count_o(wb_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    bit            we_a   [RUNC];
    logic [AW-1:0] addr_a [RUNC];
    logic [DW-1:0] data_a [RUNC];

    logic          fin_pass, fin_fail, fin_to;
    logic [CW-1:0] fin_cyc, fin_wbc;

    typedef struct {
        int            sig_k;
        logic [DW-1:0] sig_d;
        int            r0_k;
        bit            e_pass;
        bit            e_fail;
        bit            e_to;
        int            e_cyc;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wb();
        wb_we   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
    endtask

    task automatic clear_arrays();
        for (int i = 0; i < RUNC; i++) begin
            we_a[i]   = 1'b0;
            addr_a[i] = '0;
            data_a[i] = '0;
        end
    endtask

    // Starts at the first reset-phase cycle; ends at the first reset-phase cycle
    // of the next trial (restart pulsed in DONE).
    task automatic do_trial(input bit junk, input bit rs_run);
        int e;
        int res;
        e   = RUNC - 1;
        res = 2;
        for (int i = 0; i < RUNC; i++) begin
            if (res == 2 && we_a[i] && addr_a[i] == AW'(SIGA)) begin
                e   = i;
                res = (data_a[i] == DW'(PASSV)) ? 0 : 1;
            end
        end
        for (int t = 0; t <= RSTC + e + 2; t++) begin
            bit ex_run;
            bit ex_done;
            int ex_cyc;
            int ex_wbc;
            ex_run  = (t >= RSTC) && (t <= RSTC + e);
            ex_done = (t > RSTC + e);
            ex_cyc  = ex_run ? t - RSTC : (ex_done ? e : 0);
            ex_wbc  = 0;
            for (int i = 0; i <= e; i++)
                if (i < t - RSTC && we_a[i] && addr_a[i] != '0) ex_wbc++;
`ifndef CPU_TEST_WBCOUNT_EN
            ex_wbc = 0;
`endif
            chk("core_rst", 64'(core_rst), 64'(!ex_run));
            chk("running",  64'(running),  64'(ex_run));
            chk("done",     64'(done),     64'(ex_done));
            chk("pass",     64'(pass),     64'(ex_done && res == 0));
            chk("fail",     64'(fail),     64'(ex_done && res == 1));
            chk("timeout",  64'(timeout),  64'(ex_done && res == 2));
            chk("cycles",   64'(cycles),   64'(ex_cyc));
            chk("wb_count", 64'(wb_count), 64'(ex_wbc));
            if (t == RSTC + e + 1) begin
                fin_pass = pass;
                fin_fail = fail;
                fin_to   = timeout;
                fin_cyc  = cycles;
                fin_wbc  = wb_count;
            end
            if (ex_run) begin
                wb_we   = we_a[t - RSTC];
                wb_addr = addr_a[t - RSTC];
                wb_data = data_a[t - RSTC];
            end else if (junk) begin
                wb_we   = 1'($urandom_range(0, 1));
                wb_addr = ($urandom_range(0, 1) == 1) ? AW'(SIGA) : AW'($urandom_range(0, 31));
                wb_data = ($urandom_range(0, 1) == 1) ? DW'(PASSV) : DW'($urandom());
            end else begin
                idle_wb();
            end
            restart = 1'b0;
            if (t == RSTC + e + 2) restart = 1'b1;
            else if (!ex_done && junk && $urandom_range(0, 3) == 0) restart = 1'b1;
            else if (rs_run && ex_run && t == RSTC + 2) restart = 1'b1;
            step();
        end
        restart = 1'b0;
        idle_wb();
    endtask

    initial begin
        tbl[0] = '{sig_k: 3,  sig_d: 32'h1,        r0_k: -1, e_pass: 1, e_fail: 0, e_to: 0, e_cyc: 3};
        tbl[1] = '{sig_k: 5,  sig_d: 32'hDEADBEEF, r0_k: 1,  e_pass: 0, e_fail: 1, e_to: 0, e_cyc: 5};
        tbl[2] = '{sig_k: -1, sig_d: 32'h0,        r0_k: -1, e_pass: 0, e_fail: 0, e_to: 1, e_cyc: 7};
        tbl[3] = '{sig_k: 7,  sig_d: 32'h1,        r0_k: -1, e_pass: 1, e_fail: 0, e_to: 0, e_cyc: 7};
        tbl[4] = '{sig_k: 0,  sig_d: 32'h1,        r0_k: -1, e_pass: 1, e_fail: 0, e_to: 0, e_cyc: 0};
        tbl[5] = '{sig_k: 7,  sig_d: 32'h2,        r0_k: 0,  e_pass: 0, e_fail: 1, e_to: 0, e_cyc: 7};

        rst     = 1'b1;
        restart = 1'b0;
        idle_wb();
        repeat (3) step();
        chk("rst_core_rst", 64'(core_rst), 64'(1));
        chk("rst_running",  64'(running),  64'(0));
        chk("rst_done",     64'(done),     64'(0));
        chk("rst_flags",    64'({pass, fail, timeout}), 64'(0));
        chk("rst_cycles",   64'(cycles),   64'(0));
        chk("rst_wb_count", 64'(wb_count), 64'(0));
        rst = 1'b0;

        // core_rst high for exactly RSTC cycles after rst falls
        for (int t = 0; t < RSTC; t++) begin
            chk("rt_core_rst", 64'(core_rst), 64'(1));
            chk("rt_running",  64'(running),  64'(0));
            step();
        end
        chk("rt_run_core_rst", 64'(core_rst), 64'(0));
        chk("rt_run_running",  64'(running),  64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            clear_arrays();
            if (tbl[v].r0_k >= 0) begin
                we_a[tbl[v].r0_k]   = 1'b1;
                addr_a[tbl[v].r0_k] = '0;
                data_a[tbl[v].r0_k] = DW'(PASSV);
            end
            if (tbl[v].sig_k >= 0) begin
                we_a[tbl[v].sig_k]   = 1'b1;
                addr_a[tbl[v].sig_k] = AW'(SIGA);
                data_a[tbl[v].sig_k] = tbl[v].sig_d;
            end
            do_trial(1'b0, v == 2);
            chk("tbl_pass",    64'(fin_pass), 64'(tbl[v].e_pass));
            chk("tbl_fail",    64'(fin_fail), 64'(tbl[v].e_fail));
            chk("tbl_timeout", 64'(fin_to),   64'(tbl[v].e_to));
            chk("tbl_cycles",  64'(fin_cyc),  64'(tbl[v].e_cyc));
        end

        clear_arrays();
        we_a[0] = 1'b1; addr_a[0] = AW'(3);
        we_a[1] = 1'b1; addr_a[1] = AW'(0);
        we_a[2] = 1'b1; addr_a[2] = AW'(5);
        we_a[3] = 1'b1; addr_a[3] = AW'(SIGA); data_a[3] = DW'(PASSV);
        do_trial(1'b0, 1'b0);
`ifdef CPU_TEST_WBCOUNT_EN
        chk("wbc_total", 64'(fin_wbc), 64'(3));
`else
        chk("wbc_total", 64'(fin_wbc), 64'(0));
`endif
        chk("wbc_pass", 64'(fin_pass), 64'(1));

        // rst asserted in the middle of a run window
        for (int t = 0; t < RSTC + 2; t++) begin
            idle_wb();
            if (t == RSTC) begin
                wb_we   = 1'b1;
                wb_addr = AW'(7);
            end
            step();
        end
        idle_wb();
        chk("mid_running", 64'(running), 64'(1));
        chk("mid_cycles",  64'(cycles),  64'(2));
`ifdef CPU_TEST_WBCOUNT_EN
        chk("mid_wb_count", 64'(wb_count), 64'(1));
`else
        chk("mid_wb_count", 64'(wb_count), 64'(0));
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_core_rst", 64'(core_rst), 64'(1));
        chk("mid_rst_running",  64'(running),  64'(0));
        chk("mid_rst_wb_count", 64'(wb_count), 64'(0));
        chk("mid_rst_cycles",   64'(cycles),   64'(0));
        chk("mid_rst_done",     64'(done),     64'(0));

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < RUNC; i++) begin
                we_a[i]   = ($urandom_range(0, 2) == 0);
                addr_a[i] = AW'($urandom_range(0, 3));
                data_a[i] = ($urandom_range(0, 1) == 1) ? DW'(PASSV) : DW'($urandom());
            end
            do_trial(1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_test_ctrl.md
Name: cpu_test_ctrl

Overview:
- Synthesizable run controller for CPU bring-up, placed between the board/bench clock and reset and the SOPC.
- Replaces fixed-delay reset/stop timing with parametrised cycle counts: holds the core in reset for a set number of cycles, then runs it for a bounded window.
- Watches the register-file write-back port for a signature write and reports pass, fail or timeout.
- Supports restart without a global reset, so one bitstream or bench can run repeated trials.

Parameters:
- RST_CYCLES, 10, cycles core_rst is held after global reset or restart (legal range ≥1).
- RUN_CYCLES, 15, maximum run cycles before timeout (legal range ≥1).
- CNT_W, 16, width of the cycle counter (must satisfy 2^CNT_W > max(RST_CYCLES, RUN_CYCLES)).
- DATA_W, 32, write-back data width.
- ADDR_W, 5, write-back register address width.
- SIG_ADDR, 2, register index whose write ends the run.
- PASS_VALUE, 1, signature value meaning pass.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high global reset.
- restart  in  1  one-cycle pulse; honoured only in DONE.
- wb_we  in  1  core register write-back enable.
- wb_addr  in  ADDR_W  write-back register index.
- wb_data  in  DATA_W  write-back data.
- core_rst  out  1  reset to SOPC, active-high.
- running  out  1  high while the core is in the run window.
- done  out  1  trial finished (sticky until restart/rst).
- pass  out  1  signature matched PASS_VALUE.
- fail  out  1  signature written with another value.
- timeout  out  1  run window expired without a signature.
- cycles  out  CNT_W  run cycles elapsed in the current or last trial.
- wb_count  out  CNT_W  count of non-r0 write-backs (optional feature).

Behaviour:
- States: RST_PH, RUN, DONE. A 2-bit state register plus a CNT_W counter cnt.
- While rst is high:
  - State goes to RST_PH; cnt, cycles and wb_count go to 0.
  - core_rst=1; running, done, pass, fail and timeout are 0.
  - rst is honoured mid-trial from any state.
- RST_PH:
  - core_rst=1; cnt increments each cycle.
  - When cnt==RST_CYCLES-1, go to RUN and clear cnt.
  - core_rst therefore stays high for exactly RST_CYCLES cycles after rst falls.
- RUN:
  - core_rst=0, running=1; cycles increments each cycle, starting at 0 on the first RUN cycle.
  - Signature write (wb_we && wb_addr==SIG_ADDR, SIG_ADDR≠0): go to DONE next edge. Set pass=1 if wb_data==PASS_VALUE, otherwise fail=1.
  - Timeout: otherwise, when cycles==RUN_CYCLES-1, go to DONE with timeout=1.
  - Simultaneous signature and last cycle: the signature wins and timeout stays 0.
  - Writes to wb_addr 0 are ignored in all states.
  - wb_* inputs are ignored outside RUN.
- DONE:
  - core_rst=1 (core frozen), running=0, done=1.
  - pass, fail, timeout and cycles hold.
  - restart=1: go to RST_PH, clear cnt, cycles, pass, fail, timeout and done.
  - restart is ignored in RST_PH and RUN.
- Outputs are registered; there are no combinational input→output paths.
- Exactly one of pass, fail or timeout is set whenever done=1.
- cycles never exceeds RUN_CYCLES-1.

Optional Feature:
- CPU_TEST_WBCOUNT_EN.
- Defined: wb_count increments on every RUN cycle with wb_we=1 and wb_addr≠0, including the signature write itself. It holds in DONE, clears on restart or rst, and saturates at all-ones.
- Undefined: wb_count is tied to 0 and no counter logic is generated.

Test Plan:
All scenarios use RST_CYCLES=4, RUN_CYCLES=8, SIG_ADDR=2, PASS_VALUE=1.
- Reset timing: rst high 3 cycles, then low → core_rst high for exactly 4 cycles after rst falls; running rises on the 5th cycle.
- Pass: in RUN cycle 3, drive wb_we=1, wb_addr=2, wb_data=1 → next edge done=1, pass=1, fail=0, timeout=0, cycles=3, core_rst=1.
- Fail and r0 filtering: write addr 0 with data 1 at cycle 1 → no effect. Write addr 2 with data 0xDEADBEEF at cycle 5 → done=1, fail=1, pass=0.
- Timeout with tie: no signature → timeout=1 after 8 run cycles, cycles=7. Repeat with the signature write on run cycle 7 → pass=1, timeout=0.
- Restart: in DONE pulse restart → all flags clear, core_rst high for 4 cycles, then new RUN. restart pulsed during RUN → ignored.
- Counter and mid-run reset: with CPU_TEST_WBCOUNT_EN, write-backs to addr 3, 0, 5 and then 2 (data 1) → wb_count=3. Assert rst mid-RUN → next edge core_rst=1, wb_count=0, running=0.
